// File: rtl/midi_parser.sv
// MIDI channel-message parser: turns a UART byte stream into Note On/Off events.
// Define MIDI_PARSER_OMNI_EN to accept note messages on all 16 channels.
module midi_parser #(
    parameter logic [3:0] CHANNEL = 4'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [6:0] note_num,
    output logic [6:0] note_vel,
    output logic       note_on,
    output logic       note_off
);

    typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;

    state_t     state, state_n;
    logic [7:0] status, status_n;
    logic [6:0] d1, d1_n;
    logic [6:0] num_n, vel_n;
    logic       on_n, off_n;
    logic       done, chan_ok, one_byte;
    logic [6:0] m_d1, m_d2;

`ifdef MIDI_PARSER_OMNI_EN
    assign chan_ok = 1'b1;
`else
    assign chan_ok = (status[3:0] == CHANNEL);
`endif

    // Program Change (0xC_) and Channel Pressure (0xD_) carry a single data byte
    assign one_byte = (status[7:5] == 3'b110);

    always_comb begin
        state_n  = state;
        status_n = status;
        d1_n     = d1;
        num_n    = note_num;
        vel_n    = note_vel;
        on_n     = 1'b0;
        off_n    = 1'b0;
        done     = 1'b0;
        m_d1     = 7'd0;
        m_d2     = 7'd0;
        if (rx_valid) begin
            if (rx_data[7:3] == 5'b11111) begin
                // realtime bytes pass through without touching parser state
            end else if (rx_data[7:4] == 4'hF) begin
                state_n  = IDLE;
                status_n = 8'd0;
            end else if (rx_data[7]) begin
                state_n  = WAIT_D1;
                status_n = rx_data;
            end else begin
                case (state)
                    WAIT_D1: begin
                        d1_n = rx_data[6:0];
                        if (one_byte) begin
                            done = 1'b1;
                            m_d1 = rx_data[6:0];
                        end else begin
                            state_n = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        done    = 1'b1;
                        m_d1    = d1;
                        m_d2    = rx_data[6:0];
                        state_n = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
        if (done && chan_ok) begin
            case (status[7:4])
                4'h9: begin
                    num_n = m_d1;
                    vel_n = m_d2;
                    if (m_d2 != 7'd0) on_n = 1'b1;
                    else              off_n = 1'b1;
                end
                4'h8: begin
                    num_n = m_d1;
                    vel_n = m_d2;
                    off_n = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            status   <= 8'd0;
            d1       <= 7'd0;
            note_num <= 7'd0;
            note_vel <= 7'd0;
            note_on  <= 1'b0;
            note_off <= 1'b0;
        end else if (ce) begin
            state    <= state_n;
            status   <= status_n;
            d1       <= d1_n;
            note_num <= num_n;
            note_vel <= vel_n;
            note_on  <= on_n;
            note_off <= off_n;
        end
    end

endmodule

// File: tb/tb_midi_parser.sv
// Scoreboard bench for midi_parser: directed byte streams, expected events queued
// at issue time and checked by an independent monitor on ce-qualified edges.
module tb_midi_parser;

    typedef struct {
        bit       on;
        bit [6:0] num;
        bit [6:0] vel;
        int       due;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ce = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic [6:0] note_num, note_vel;
    logic       note_on, note_off;

    int   total = 0;
    int   bad = 0;
    int   ce_edges = 0;
    bit   ce_at_edge = 1'b0;
    ev_t  sb[$];
    bit [6:0] last_num = 7'd0, last_vel = 7'd0;

    midi_parser #(.CHANNEL(4'd0)) dut (
        .clk(clk), .rst(rst), .ce(ce), .rx_data(rx_data), .rx_valid(rx_valid),
        .note_num(note_num), .note_vel(note_vel), .note_on(note_on), .note_off(note_off)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ce_at_edge = ce;
        if (ce && !rst) ce_edges = ce_edges + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Queue an event due on the ce-edge that accepts the next byte sent
    task automatic expect_ev(input bit on, input bit [6:0] num, input bit [6:0] vel);
        ev_t e;
        e.on = on; e.num = num; e.vel = vel; e.due = ce_edges + 1;
        sb.push_back(e);
        last_num = num;
        last_vel = vel;
    endtask

    task automatic send(input logic [7:0] b);
        ce = 1'b1; rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_ce(input logic [7:0] b);
        ce = 1'b1; rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_hold(input string name);
        chk({name, "_num"}, int'(note_num), int'(last_num));
        chk({name, "_vel"}, int'(note_vel), int'(last_vel));
    endtask

    // Monitor: a new event is any strobe seen after a ce=1 edge; between ce edges outputs must hold
    initial begin
        logic [15:0] prev = 16'd0;
        forever begin
            @(negedge clk);
            if (note_on && note_off) chk("both_strobes", 1, 0);
            if (!ce_at_edge && !rst) begin
                chk("hold_no_ce", int'({note_num, note_vel, note_on, note_off}), int'(prev));
            end else if (note_on || note_off) begin
                if (sb.size() == 0) begin
                    chk("unexpected_strobe", int'({note_on, note_off, note_num}), 0);
                end else begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("ev_on",   int'(note_on),  int'(e.on));
                    chk("ev_off",  int'(note_off), int'(!e.on));
                    chk("ev_num",  int'(note_num), int'(e.num));
                    chk("ev_vel",  int'(note_vel), int'(e.vel));
                    chk("ev_when", ce_edges, e.due);
                end
            end
            prev = {note_num, note_vel, note_on, note_off};
        end
    end

    initial begin
        int wait_cnt;
        idle(2);
        rst = 1'b0;
        chk("rst_num", int'(note_num), 0);
        chk("rst_vel", int'(note_vel), 0);
        chk("rst_on",  int'(note_on), 0);
        chk("rst_off", int'(note_off), 0);

        // basic note on
        send(8'h90); send(8'h3C); expect_ev(1, 7'h3C, 7'h64); send(8'h64);
        idle(3);

        // running status, then velocity-0 note on
        send(8'h90); send(8'h3C); expect_ev(1, 7'h3C, 7'h64); send(8'h64);
        send(8'h40); expect_ev(1, 7'h40, 7'h50); send(8'h50);
        send(8'h3C); expect_ev(0, 7'h3C, 7'h00); send(8'h00);
        idle(3);

        // realtime bytes interleaved in a note off
        send(8'h80); send(8'hF8); send(8'h3C); send(8'hFE);
        expect_ev(0, 7'h3C, 7'h20); send(8'h20);
        idle(3);

        // other channel
        send(8'h91); send(8'h3C);
`ifdef MIDI_PARSER_OMNI_EN
        expect_ev(1, 7'h3C, 7'h64);
`endif
        send(8'h64);
        idle(3);
        chk_hold("chan_filter");

        // aborted note, program change, then a fresh note on
        send(8'h90); send(8'h3C); send(8'hC0); send(8'h05);
        send(8'h90); send(8'h45); expect_ev(1, 7'h45, 7'h7F); send(8'h7F);
        idle(3);

        // sysex clears running status; orphan data is dropped
        send(8'hF0); send(8'h7E); send(8'h01); send(8'hF7);
        send(8'h3C); send(8'h64); send(8'h40); send(8'h40);
        idle(3);
        chk_hold("sysex");

        // reset mid-message
        send(8'h90); send(8'h3C);
        rst = 1'b1; idle(1); rst = 1'b0;
        last_num = 7'd0; last_vel = 7'd0;
        send(8'h64);
        idle(3);
        chk_hold("rst_mid");

        // note on with ce toggling; strobe must span exactly one ce cycle
        send_ce(8'h90); send_ce(8'h3C); expect_ev(1, 7'h3C, 7'h64); send_ce(8'h64);
        repeat (4) begin ce = 1'b0; idle(2); ce = 1'b1; idle(1); end
        ce = 1'b1;

        // note off on channel 0 with release velocity
        send(8'h80); send(8'h11); expect_ev(0, 7'h11, 7'h7F); send(8'h7F);

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            idle(1);
            wait_cnt++;
        end
        idle(2);
        chk("sb_empty", sb.size(), 0);
        chk_hold("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/midi_parser.md
Name: midi_parser

Overview:
- Byte-level MIDI channel-message parser that sits directly upstream of the polyphony voice allocator.
- Consumes received MIDI bytes from the UART receiver.
- Emits one note event per complete Note On / Note Off message: note_num, note_vel, and a single-cycle note_on or note_off strobe.
- Handles running status, realtime-byte interleaving, channel filtering and velocity-0 Note On.

Parameters:
- CHANNEL, 4'd0: MIDI channel (0-15) accepted when channel filtering is active.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ce  in  1  clock enable; all state, including output strobes, advances only on ce=1 cycles
- rx_data  in  8  received MIDI byte
- rx_valid  in  1  rx_data valid; sampled only when ce=1
- note_num  out  7  key number of the last emitted event
- note_vel  out  7  velocity of the last emitted event
- note_on  out  1  Note On strobe
- note_off  out  1  Note Off strobe

Behaviour:
- Reset:
  - note_num=0, note_vel=0, note_on=0, note_off=0.
  - FSM goes to IDLE; running status is cleared.
  - A reset mid-message discards the partial message.
- Byte classes, decided on rx_data when ce & rx_valid:
  - 0xF8-0xFF (realtime): ignored completely. No state change, and running status is kept.
  - 0xF0-0xF7 (system common/SysEx): clears running status and goes to IDLE. The data bytes that follow are discarded until a new channel status byte arrives.
  - 0x80-0xEF (channel status): latched as running status and sets the expected data-byte count. The count is 1 for 0xC_/0xD_ and 2 for all others. The FSM goes to WAIT_D1. A status byte arriving mid-message aborts the pending message.
  - 0x00-0x7F (data): processed according to the FSM state.
- FSM states: IDLE, WAIT_D1, WAIT_D2.
  - IDLE: data bytes are discarded.
  - WAIT_D1, on a data byte:
    - Latch it as d1.
    - If the count is 2, go to WAIT_D2.
    - If the count is 1, the message is complete; go back to WAIT_D1 (running status).
  - WAIT_D2, on a data byte:
    - The message is complete with d2.
    - Go back to WAIT_D1 with running status retained.
- Event emission on message complete:
  - Status 0x9n with d2≠0: note_num<=d1, note_vel<=d2, note_on<=1.
  - Status 0x9n with d2=0: note_num<=d1, note_vel<=0, note_off<=1.
  - Status 0x8n: note_num<=d1, note_vel<=d2 (release velocity), note_off<=1.
  - Any other status: no output change.
  - Channel n must equal CHANNEL, otherwise the message is silently dropped. Parsing and running status still proceed.
- Latency: the strobe is high on the ce-cycle following acceptance of the final data byte.
- Strobes:
  - A strobe lasts exactly one ce-qualified cycle. With ce held low it stays high until the next ce=1 cycle.
  - note_on and note_off are never high together.
- note_num and note_vel hold their values until the next emitted event.
- Back-to-back bytes on consecutive ce-cycles are supported. There is no backpressure; every valid byte is consumed.

Optional Feature:
- Macro: MIDI_PARSER_OMNI_EN.
- Defined: omni mode. Note messages on all 16 channels are accepted, and CHANNEL is ignored.
- Undefined: only channel CHANNEL is accepted, as described in Behaviour.

Test Plan:
- Note On with CHANNEL=0:
  - Stimulus: bytes 0x90,0x3C,0x64.
  - Response: one cycle later note_on=1 for one cycle, note_num=0x3C, note_vel=0x64, note_off=0.
- Running status:
  - Stimulus: 0x90,0x3C,0x64,0x40,0x50,0x3C,0x00.
  - Response: note_on (0x3C/0x64), then note_on (0x40/0x50), then note_off with note_num=0x3C, note_vel=0.
- Realtime interleave:
  - Stimulus: 0x80,0xF8,0x3C,0xFE,0x20.
  - Response: a single note_off with note_num=0x3C, note_vel=0x20. The realtime bytes have no effect.
- Channel filter and abort:
  - Stimulus (a): 0x91,0x3C,0x64. Response: no strobe (macro off); note_on=1 with macro on.
  - Stimulus (b): 0x90,0x3C,0xC0,0x05,0x90,0x45,0x7F. Response: only note_on (0x45/0x7F).
- SysEx and orphan data:
  - Stimulus: 0xF0,0x7E,0x01,0xF7,0x3C,0x64.
  - Response: no strobe ever; FSM remains in IDLE.
- Reset and ce:
  - Stimulus (a): 0x90,0x3C, then rst=1 for one cycle, then 0x64. Response: no strobe.
  - Stimulus (b): full Note On with ce toggling 1/0. Response: the strobe spans exactly one ce=1 cycle.
